// File: rtl/auto_play_sequencer.sv
// Purpose : auto-play engine; walks a {index, beats} song ROM and drives the tone-table index.
// Latency : all outputs registered; first note plays 2 cycles after start (FETCH + LOAD).
// Backpres: none; start is ignored while busy, stop aborts from any busy state.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start, stop     1-cycle control pulses (stop wins when both are high)
//   loop            level; replay from entry 0 at end of song instead of finishing
//   romAddr         registered song ROM address
//   romData         {index[7:3], beats[2:0]}, valid one cycle after romAddr changes
//   autoPlayIndex   note code to the tone table, 0 = silence
//   noteStrobe      1-cycle pulse on the first PLAY cycle of every entry
//   playing         high whenever the engine is not idle
//   done            1-cycle pulse when a non-looping song finishes
module auto_play_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int SONG_LEN    = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [7:0]        romData,
    output logic [4:0]        autoPlayIndex,
    output logic              noteStrobe,
    output logic              playing,
    output logic              done
);

    // 3 bits of beat count on top of one beat's worth of cycles, so a
    // 7-beat note never wraps the duration counter.
    localparam int DUR_W = 3 + $clog2(BEAT_CYCLES);

    localparam logic [DUR_W-1:0]  BEAT_LEN  = DUR_W'(BEAT_CYCLES);
    localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_CYCLES);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [4:0]        note_idx_q, note_idx_d;
    logic [DUR_W-1:0]  dur_cnt_q,  dur_cnt_d;
    logic [4:0]        idx_out_q,  idx_out_d;
    logic              strobe_q,   strobe_d;
    logic              playing_q,  playing_d;
    logic              done_q,     done_d;

    // ROM word fields
    logic [4:0]       rom_idx;
    logic [2:0]       rom_beats;
    logic [DUR_W-1:0] play_last;
    logic             end_song;

    assign rom_idx   = romData[7:3];
    assign rom_beats = romData[2:0];

    // PLAY lasts beats*BEAT_CYCLES - GAP_CYCLES cycles; the counter runs
    // down to zero, so it is loaded with one less than that.
    assign play_last = DUR_W'(rom_beats) * BEAT_LEN - GAP_LEN - DUR_ONE;

    //------------------------------------------------------------------
    // Next-state and registered-output logic
    //------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        note_idx_d = note_idx_q;
        dur_cnt_d  = dur_cnt_q;
        done_d     = 1'b0;
        end_song   = 1'b0;

        if (stop && (state_q != S_IDLE)) begin
            // abort: silent, rewound, and no done pulse
            state_d    = S_IDLE;
            rom_addr_d = '0;
            dur_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d    = S_FETCH;
                        rom_addr_d = '0;
                    end
                end

                // romAddr is already on the bus; wait for the ROM read
                S_FETCH: begin
                    state_d = S_LOAD;
                end

                S_LOAD: begin
                    note_idx_d = rom_idx;
                    if (rom_beats == 3'd0) begin
                        end_song = 1'b1;
                    end else begin
                        dur_cnt_d = play_last;
                        state_d   = S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (dur_cnt_q == '0) begin
                        dur_cnt_d = GAP_LEN - DUR_ONE;
                        state_d   = S_GAP;
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_ONE;
                    end
                end

                S_GAP: begin
                    if (dur_cnt_q == '0) begin
                        if (rom_addr_q == LAST_ADDR) begin
                            end_song = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_ONE;
                            state_d    = S_FETCH;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_ONE;
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    rom_addr_d = '0;
                    dur_cnt_d  = '0;
                end
            endcase

            // End of song is a decision, not a separate cycle: loop is
            // sampled here and either rewinds straight into FETCH or
            // finishes with a done pulse.
            if (end_song) begin
                rom_addr_d = '0;
                dur_cnt_d  = '0;
                if (loop) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        // Outputs are computed from the next state so they line up with
        // the state register instead of lagging it by a cycle.
        playing_d = (state_d != S_IDLE);
        idx_out_d = (state_d == S_PLAY) ? note_idx_d : 5'd0;
        strobe_d  = (state_q == S_LOAD) && (state_d == S_PLAY);
    end

    //------------------------------------------------------------------
    // State and output registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
            idx_out_q  <= '0;
            strobe_q   <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            note_idx_q <= note_idx_d;
            dur_cnt_q  <= dur_cnt_d;
            idx_out_q  <= idx_out_d;
            strobe_q   <= strobe_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
        end
    end

    assign romAddr       = rom_addr_q;
    assign autoPlayIndex = idx_out_q;
    assign noteStrobe    = strobe_q;
    assign playing       = playing_q;
    assign done          = done_q;

endmodule

// File: tb/tb_auto_play_sequencer.sv
// Purpose : self-checking bench for auto_play_sequencer with a cycle-trace scoreboard.
// Latency : expected per-cycle outputs are queued at start and popped each falling edge.
// Backpres: n/a (bench).
module tb_auto_play_sequencer;

    localparam int B   = 10;
    localparam int G   = 2;
    localparam int LEN = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          loop;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [4:0]    auto_idx;
    logic          note_stb;
    logic          playing;
    logic          done;

    logic [7:0] rom [0:LEN-1];

    always #5 clk = ~clk;

    // synchronous song ROM: data follows the address by one cycle
    always @(posedge clk) rom_data <= rom[rom_addr];

    auto_play_sequencer #(
        .BEAT_CYCLES (B),
        .GAP_CYCLES  (G),
        .SONG_LEN    (LEN),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .loop          (loop),
        .romAddr       (rom_addr),
        .romData       (rom_data),
        .autoPlayIndex (auto_idx),
        .noteStrobe    (note_stb),
        .playing       (playing),
        .done          (done)
    );

    typedef struct packed {
        logic [4:0]    idx;
        logic          stb;
        logic          ply;
        logic          dn;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    exp_t mon_obs;
    int   mon_cyc;
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic [4:0] idx, input logic stb,
                                input logic ply, input logic dn, input int addr);
        exp_t e;
        e.idx  = idx;
        e.stb  = stb;
        e.ply  = ply;
        e.dn   = dn;
        e.addr = AW'(addr);
        return e;
    endfunction

    // Expected output trace from the first cycle after start is sampled:
    // each entry is FETCH, LOAD, beats*B-G PLAY cycles, G GAP cycles.
    task automatic gen_expected(input int ncyc, input bit lp);
        int         n;
        int         addr;
        int         beats;
        int         play_len;
        logic [7:0] word;
        logic [4:0] idx;
        bit         fin;
        n    = 0;
        addr = 0;
        fin  = 0;
        while (n < ncyc && !fin) begin
            word  = rom[addr];
            beats = int'(word[2:0]);
            idx   = word[7:3];
            for (int k = 0; k < 2; k++) begin
                if (n < ncyc) sb_q.push_back(mk(5'd0, 1'b0, 1'b1, 1'b0, addr));
                n++;
            end
            if (beats == 0) begin
                addr = 0;
                if (!lp) begin
                    if (n < ncyc) sb_q.push_back(mk(5'd0, 1'b0, 1'b0, 1'b1, 0));
                    n++;
                    fin = 1;
                end
            end else begin
                play_len = beats * B - G;
                for (int k = 0; k < play_len; k++) begin
                    if (n < ncyc) sb_q.push_back(mk(idx, k == 0, 1'b1, 1'b0, addr));
                    n++;
                end
                for (int k = 0; k < G; k++) begin
                    if (n < ncyc) sb_q.push_back(mk(5'd0, 1'b0, 1'b1, 1'b0, addr));
                    n++;
                end
                if (addr == LEN - 1) begin
                    addr = 0;
                    if (!lp) begin
                        if (n < ncyc) sb_q.push_back(mk(5'd0, 1'b0, 1'b0, 1'b1, 0));
                        n++;
                        fin = 1;
                    end
                end else begin
                    addr++;
                end
            end
        end
        while (n < ncyc) begin
            sb_q.push_back(mk(5'd0, 1'b0, 1'b0, 1'b0, 0));
            n++;
        end
    endtask

    // scoreboard monitor: one trace comparison per cycle while entries remain
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_obs = {auto_idx, note_stb, playing, done, rom_addr};
            checks++;
            if (mon_obs !== mon_exp) begin
                failures++;
                $display("FAIL trace cyc=%0d got idx=%0h stb=%b ply=%b done=%b addr=%0d required idx=%0h stb=%b ply=%b done=%b addr=%0d",
                         mon_cyc, mon_obs.idx, mon_obs.stb, mon_obs.ply, mon_obs.dn, mon_obs.addr,
                         mon_exp.idx, mon_exp.stb, mon_exp.ply, mon_exp.dn, mon_exp.addr);
            end
            mon_cyc++;
        end
    end

    // Pulses start, queues the expected trace and returns at the falling
    // edge of trace cycle 0.
    task automatic start_song(input int ncyc, input bit lp);
        @(negedge clk);
        loop  = lp;
        start = 1'b1;
        @(posedge clk);
        mon_cyc = 0;
        gen_expected(ncyc, lp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        load_rom(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rom_addr !== 2'd0) begin failures++; $display("FAIL reset_addr got %0d required 0", rom_addr); end
        checks++;
        if (auto_idx !== 5'd0) begin failures++; $display("FAIL reset_idx got %0h required 0", auto_idx); end
        checks++;
        if (note_stb !== 1'b0) begin failures++; $display("FAIL reset_strobe got %b required 0", note_stb); end
        checks++;
        if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got %b required 0", playing); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b required 0", done); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (playing !== 1'b0) begin failures++; $display("FAIL idle_after_reset playing got %b required 0", playing); end
    endtask

    // 09/1, 0A/2, 0B/1, terminator: notes fill cycles 0..45, terminator
    // FETCH 46 / LOAD 47, done at 48.
    task automatic test_song_end;
        int n_stb;
        int n_done;
        int done_cyc;
        n_stb    = 0;
        n_done   = 0;
        done_cyc = -1;
        load_rom({5'h09, 3'd1}, {5'h0A, 3'd2}, {5'h0B, 3'd1}, 8'h00);
        start_song(56, 1'b0);
        for (int c = 1; c < 56; c++) begin
            @(negedge clk);
            if (note_stb === 1'b1) n_stb++;
            if (done === 1'b1) begin n_done++; done_cyc = c; end
        end
        checks++;
        if (n_stb != 3) begin failures++; $display("FAIL song_end_strobes got %0d required 3", n_stb); end
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL song_end_done_count got %0d required 1", n_done); end
        checks++;
        if (done_cyc != 48) begin failures++; $display("FAIL song_end_done_cycle got %0d required 48", done_cyc); end
    endtask

    // all entries non-zero: done follows the GAP of the last entry; a start
    // pulse during PLAY must not disturb the trace
    task automatic test_full_song;
        int n_stb;
        int n_done;
        int done_cyc;
        n_stb    = 0;
        n_done   = 0;
        done_cyc = -1;
        load_rom({5'h01, 3'd1}, {5'h02, 3'd1}, {5'h03, 3'd2}, {5'h04, 3'd1});
        start_song(62, 1'b0);
        for (int c = 1; c < 62; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (note_stb === 1'b1) n_stb++;
            if (done === 1'b1) begin n_done++; done_cyc = c; end
        end
        start = 1'b0;
        checks++;
        if (n_stb != 4) begin failures++; $display("FAIL full_song_strobes got %0d required 4", n_stb); end
        checks++;
        if (n_done != 1 || done_cyc != 58) begin
            failures++;
            $display("FAIL full_song_done got count=%0d cycle=%0d required count=1 cycle=58", n_done, done_cyc);
        end
        checks++;
        if (rom_addr !== 2'd0) begin failures++; $display("FAIL full_song_addr got %0d required 0", rom_addr); end
    endtask

    // loop: entry 0 replays after the terminator with no done pulse
    task automatic test_loop;
        int first_stb;
        int second_stb;
        int n_done;
        first_stb  = -1;
        second_stb = -1;
        n_done     = 0;
        load_rom({5'h09, 3'd1}, {5'h0A, 3'd2}, {5'h0B, 3'd1}, 8'h00);
        start_song(110, 1'b1);
        for (int c = 1; c < 110; c++) begin
            @(negedge clk);
            if (note_stb === 1'b1 && auto_idx === 5'h09) begin
                if (first_stb < 0) first_stb = c;
                else if (second_stb < 0) second_stb = c;
            end
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (second_stb - first_stb != 48) begin
            failures++;
            $display("FAIL loop_restart_interval got %0d required 48", second_stb - first_stb);
        end
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL loop_done got %0d required 0", n_done); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop = 1'b0;
        checks++;
        if ({playing, done, auto_idx, rom_addr} !== 9'd0) begin
            failures++;
            $display("FAIL loop_stop got ply=%b done=%b idx=%0h addr=%0d required all 0", playing, done, auto_idx, rom_addr);
        end
    endtask

    // stop in the 5th PLAY cycle of entry 1 (trace cycle 18)
    task automatic test_stop;
        int n_busy;
        load_rom({5'h09, 3'd1}, {5'h0A, 3'd2}, {5'h0B, 3'd1}, 8'h00);
        start_song(19, 1'b0);
        for (int c = 1; c < 19; c++) begin
            @(negedge clk);
            if (c == 18) stop = 1'b1;
        end
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({playing, done, note_stb, auto_idx, rom_addr} !== 10'd0) begin
            failures++;
            $display("FAIL stop_abort got ply=%b done=%b stb=%b idx=%0h addr=%0d required all 0",
                     playing, done, note_stb, auto_idx, rom_addr);
        end
        n_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || playing !== 1'b0) n_busy++;
        end
        checks++;
        if (n_busy != 0) begin failures++; $display("FAIL stop_quiet got %0d active cycles required 0", n_busy); end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_busy = 0;
        repeat (4) begin
            if (playing !== 1'b0) n_busy++;
            @(negedge clk);
        end
        checks++;
        if (n_busy != 0) begin failures++; $display("FAIL start_stop_same got %0d active cycles required 0", n_busy); end
    endtask

    // rest entry 00/3: strobe at cycle 2, silent 30 cycles, entry 1 fetched at 32
    task automatic test_rest;
        int n_stb;
        int addr_at_32;
        n_stb      = 0;
        addr_at_32 = -1;
        load_rom({5'h00, 3'd3}, {5'h05, 3'd1}, 8'h00, 8'h00);
        start_song(50, 1'b0);
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            if (note_stb === 1'b1) n_stb++;
            if (c == 32) addr_at_32 = int'(rom_addr);
        end
        checks++;
        if (n_stb != 2) begin failures++; $display("FAIL rest_strobes got %0d required 2", n_stb); end
        checks++;
        if (addr_at_32 != 1) begin failures++; $display("FAIL rest_next_fetch got addr=%0d required 1", addr_at_32); end
    endtask

    // reset during GAP of entry 0 (cycle 10) after an ignored start in PLAY
    task automatic test_reset_mid;
        int n_busy;
        load_rom({5'h09, 3'd1}, {5'h0A, 3'd2}, {5'h0B, 3'd1}, 8'h00);
        start_song(11, 1'b0);
        for (int c = 1; c < 11; c++) begin
            @(negedge clk);
            start = (c == 4);
            if (c == 10) rst_n = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({playing, done, note_stb, auto_idx, rom_addr} !== 10'd0) begin
            failures++;
            $display("FAIL reset_mid got ply=%b done=%b stb=%b idx=%0h addr=%0d required all 0",
                     playing, done, note_stb, auto_idx, rom_addr);
        end
        rst_n  = 1'b1;
        n_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (playing !== 1'b0 || note_stb !== 1'b0) n_busy++;
        end
        checks++;
        if (n_busy != 0) begin failures++; $display("FAIL reset_mid_no_restart got %0d active cycles required 0", n_busy); end
    endtask

    initial begin
        test_reset();
        test_song_end();
        test_full_song();
        test_loop();
        test_stop();
        test_rest();
        test_reset_mid();
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got %0d left required 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
